// File: rtl/sweeper_pkg.sv
// Shared definitions for exhaustive-stimulus sequencers: sweep state encoding
// and the combination-count helper.
package sweeper_pkg;

   typedef logic [1:0] sweep_state_t;

   localparam sweep_state_t IDLE = 2'd0;
   localparam sweep_state_t RUN  = 2'd1;
   localparam sweep_state_t DONE = 2'd2;

   // Number of input combinations for an n-input block under test.
   function automatic int unsigned num_combos(input int unsigned n_inputs);
      return 32'd1 << n_inputs;
   endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Hold-time counter: counts 0..HOLD_CYCLES-1 while enabled and flags the final
// cycle of each hold window.
module sweep_hold_timer #(
   parameter int unsigned HOLD_CYCLES = 20,
   parameter int unsigned CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic last
);

   logic [CNT_W-1:0] hold_cnt_q;
   logic [CNT_W-1:0] hold_cnt_d;

   assign last = (hold_cnt_q == CNT_W'(HOLD_CYCLES - 1));

   // Wrap on the last cycle so back-to-back windows need no extra clear.
   always_comb begin
      hold_cnt_d = hold_cnt_q;
      if (clear) begin
         hold_cnt_d = '0;
      end else if (enable) begin
         hold_cnt_d = last ? '0 : hold_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= '0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
      end
   end

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives every input combination of a small combinational block, samples its
// output at the end of each hold window and checks it against EXPECTED.
module truth_table_sweeper
   import sweeper_pkg::*;
#(
   parameter int unsigned                         N_INPUTS    = 3,
   parameter int unsigned                         HOLD_CYCLES = 20,
   parameter logic [num_combos(N_INPUTS)-1:0]     EXPECTED    = 8'h96
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic                            abort,
   input  logic                            dut_y,
   output logic [N_INPUTS-1:0]             x,
   output logic                            busy,
   output logic                            done,
   output logic                            pass,
   output logic [N_INPUTS:0]               err_count,
   output logic [num_combos(N_INPUTS)-1:0] capture
);

   localparam int unsigned NUM = num_combos(N_INPUTS);

   sweep_state_t        state_q, state_d;
   logic [N_INPUTS-1:0] x_q, x_d;
   logic [N_INPUTS:0]   err_q, err_d;
   logic [NUM-1:0]      cap_q, cap_d;
   logic                pass_q, pass_d;

   logic hold_last;
   logic last_combo;
   logic mismatch;

   sweep_hold_timer #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_hold_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  ((state_q != RUN) || abort),
      .enable (state_q == RUN),
      .last   (hold_last)
   );

   assign last_combo = (x_q == N_INPUTS'(NUM - 1));
   assign mismatch   = dut_y ^ EXPECTED[x_q];

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      err_d   = err_q;
      cap_d   = cap_q;
      pass_d  = pass_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RUN;
               x_d     = '0;
               err_d   = '0;
               cap_d   = '0;
               pass_d  = 1'b0;
            end
         end
         RUN: begin
            // Abort wins over a coincident sample, so the partial results stay untouched.
            if (abort) begin
               state_d = IDLE;
               x_d     = '0;
            end else if (hold_last) begin
               cap_d[x_q] = dut_y;
               err_d      = err_q + {{N_INPUTS{1'b0}}, mismatch};
               if (last_combo) begin
                  state_d = DONE;
                  x_d     = '0;
                  pass_d  = (err_d == '0);
               end else begin
                  x_d = x_q + N_INPUTS'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            x_d     = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         x_q     <= '0;
         err_q   <= '0;
         cap_q   <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         err_q   <= err_d;
         cap_q   <= cap_d;
         pass_q  <= pass_d;
      end
   end

   assign x         = x_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);
   assign pass      = pass_q;
   assign err_count = err_q;
   assign capture   = cap_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Self-checking bench for truth_table_sweeper: vector table, hand-written corner
// sequences and randomised sweeps against a behavioural model.
module tb_truth_table_sweeper;

   localparam int unsigned H     = 20;
   localparam int unsigned NC    = 8;
   localparam int unsigned SWEEP = NC * H;
   localparam logic [7:0]  EXP_TT = 8'h96;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0, abort = 1'b0, start1 = 1'b0, abort1 = 1'b0;
   logic [7:0] tt = 8'h96, tt1 = 8'h96;
   logic [2:0] x, x1;
   logic busy, done, pass, busy1, done1, pass1;
   logic [3:0] err, err1;
   logic [7:0] cap, cap1;
   logic y, y1;

   int errors = 0;
   int checks = 0;

   // Behavioural blocks under test: a lookup table indexed by the driven inputs.
   assign y  = tt[x];
   assign y1 = tt1[x1];

   always #5 clk = ~clk;

   truth_table_sweeper #(.N_INPUTS(3), .HOLD_CYCLES(H), .EXPECTED(8'h96)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .dut_y(y),
      .x(x), .busy(busy), .done(done), .pass(pass), .err_count(err), .capture(cap)
   );

   truth_table_sweeper #(.N_INPUTS(3), .HOLD_CYCLES(1), .EXPECTED(8'h96)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .dut_y(y1),
      .x(x1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .capture(cap1)
   );

   typedef struct {
      logic [7:0]  tt;
      int unsigned abort_at;
      logic [7:0]  cap;
      int unsigned err;
      logic        pass;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int unsigned popcnt8(input logic [7:0] v);
      int unsigned n = 0;
      for (int i = 0; i < 8; i++) n += int'(v[i]);
      return n;
   endfunction

   // Results expected after a sweep of table t, aborted at edge E+a (a=0: never).
   function automatic void model(input logic [7:0] t, input int unsigned a,
                                 output logic [7:0] mc, output int unsigned me,
                                 output logic mp);
      logic [7:0]  all_ones = 8'hFF;
      logic [7:0]  mask;
      int unsigned n;
      n    = (a >= 1 && a <= SWEEP) ? (a - 1) / H : NC;
      mask = all_ones >> (NC - n);
      mc   = t & mask;
      me   = popcnt8((t ^ EXP_TT) & mask);
      mp   = (n == NC) && (me == 0);
   endfunction

   task automatic run_sweep(input string tag, input logic [7:0] table_v,
                            input int unsigned abort_at, input logic [7:0] exp_cap,
                            input int unsigned exp_err, input logic exp_pass);
      logic        aborted;
      int unsigned last_c;
      logic [2:0]  ex;
      logic        eb, ed;
      tt = table_v;
      start = 1'b1;
      tick();
      start = 1'b0;
      aborted = (abort_at >= 1 && abort_at <= SWEEP);
      last_c  = aborted ? abort_at + 2 : SWEEP + 2;
      for (int unsigned c = 0; c <= last_c; c++) begin
         if (aborted && c >= abort_at) begin
            ex = 3'd0; eb = 1'b0; ed = 1'b0;
         end else if (c < SWEEP) begin
            ex = 3'(c / H); eb = 1'b1; ed = 1'b0;
         end else if (c == SWEEP) begin
            ex = 3'd0; eb = 1'b0; ed = 1'b1;
         end else begin
            ex = 3'd0; eb = 1'b0; ed = 1'b0;
         end
         check({tag, ".trace"}, {x, busy, done}, {ex, eb, ed});
         abort = (abort_at != 0) && (c + 1 == abort_at);
         if (c != last_c) tick();
      end
      abort = 1'b0;
      check({tag, ".capture"}, cap, exp_cap);
      check({tag, ".err_count"}, err, exp_err);
      check({tag, ".pass"}, pass, exp_pass);
   endtask

   initial begin
      logic [7:0]  mc, rt;
      int unsigned me, ra;
      logic        mp;

      vecs[0] = '{8'h96, 0,   8'h96, 0, 1'b1};
      vecs[1] = '{8'h00, 0,   8'h00, 4, 1'b0};
      vecs[2] = '{8'hFF, 0,   8'hFF, 4, 1'b0};
      vecs[3] = '{8'h69, 0,   8'h69, 8, 1'b0};
      vecs[4] = '{8'h97, 0,   8'h97, 1, 1'b0};
      vecs[5] = '{8'h96, 50,  8'h02, 0, 1'b0};
      vecs[6] = '{8'h00, 50,  8'h00, 1, 1'b0};
      vecs[7] = '{8'h96, 60,  8'h02, 0, 1'b0};
      vecs[8] = '{8'h96, 160, 8'h16, 0, 1'b0};

      // Reset values while rst_n is low
      #2;
      check("reset.outs", {x, busy, done, pass, err, cap}, 0);
      check("reset.outs1", {x1, busy1, done1, pass1, err1, cap1}, 0);
      #10;
      rst_n = 1'b1;
      tick();
      check("idle.outs", {x, busy, done, pass, err, cap}, 0);

      for (int i = 0; i < 9; i++) begin
         run_sweep($sformatf("vec%0d", i), vecs[i].tt, vecs[i].abort_at,
                   vecs[i].cap, vecs[i].err, vecs[i].pass);
         tick();
      end

      // Asynchronous reset between edges in the middle of a sweep
      tt = 8'h96;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int c = 0; c < 75; c++) tick();
      check("midreset.before", {x, busy, cap}, {3'd3, 1'b1, 8'h06});
      #2;
      rst_n = 1'b0;
      #1;
      check("midreset.outs", {x, busy, done, pass, err, cap}, 0);
      #1;
      rst_n = 1'b1;
      tick();
      run_sweep("after_reset", 8'h96, 0, 8'h96, 0, 1'b1);
      tick();

      // Start held high: ignored during RUN/DONE, second sweep at E+162
      tt = 8'h00;
      start = 1'b1;
      tick();
      for (int unsigned c = 0; c <= 162; c++) begin
         if (c < SWEEP)       check("held.trace", {x, busy, done}, {3'(c / H), 2'b10});
         else if (c == SWEEP) check("held.trace", {x, busy, done}, {3'd0, 2'b01});
         else if (c == 161)   check("held.trace", {x, busy, done}, {3'd0, 2'b00});
         else                 check("held.trace", {x, busy, done}, {3'd0, 2'b10});
         if (c == SWEEP) check("held.err_first", err, 4);
         if (c == 162)   check("held.cleared", {err, cap, pass}, 0);
         if (c != 162) tick();
      end
      start = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("held.aborted", {busy, done, x}, 0);
      tick();

      // HOLD_CYCLES=1 instance: one combination per cycle
      tt1 = 8'h96;
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int unsigned c = 0; c <= 9; c++) begin
         if (c < NC)       check("h1.trace", {x1, busy1, done1}, {3'(c), 2'b10});
         else if (c == NC) check("h1.trace", {x1, busy1, done1}, {3'd0, 2'b01});
         else              check("h1.trace", {x1, busy1, done1}, {3'd0, 2'b00});
         if (c != 9) tick();
      end
      check("h1.result", {cap1, err1, pass1}, {8'h96, 4'd0, 1'b1});

      for (int i = 0; i < 4; i++) begin
         tt1 = 8'($urandom);
         start1 = 1'b1;
         tick();
         start1 = 1'b0;
         for (int c = 0; c < 10; c++) tick();
         model(tt1, 0, mc, me, mp);
         check("h1.rand", {cap1, err1, pass1}, {mc, 4'(me), mp});
      end

      // Randomised tables and abort points against the model
      for (int i = 0; i < 24; i++) begin
         rt = 8'($urandom);
         ra = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 162) : 0;
         model(rt, ra, mc, me, mp);
         run_sweep($sformatf("rand%0d", i), rt, ra, mc, me, mp);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
# truth_table_sweeper

- Hardware stimulus sequencer and checker for a small combinational block under test with inputs `x2..x0` and output `y`.
- On `start`, it drives every input combination in ascending binary order and holds each one for a programmable number of cycles.
- It samples `y` at the end of each hold, compares it against a parameterised expected truth table, and reports the captured table, the mismatch count and pass/fail.
- It replaces the free-running stimulus process in board-level bring-up, so exhaustive checks run in silicon.

## Interface
Parameters:
- `N_INPUTS`, 3: width of the DUT input vector; 2^N_INPUTS combinations.
- `HOLD_CYCLES`, 20: cycles each combination is driven; legal range ≥1.
- `EXPECTED`, 8'h96: expected truth table, 2^N_INPUTS bits; bit i is the expected `y` for input value i.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a sweep; honoured only in IDLE.
- `abort` in 1: terminate a sweep; honoured only in RUN.
- `dut_y` in 1: DUT output.
- `x` out N_INPUTS: DUT input vector; `x[N_INPUTS-1]` maps to `x2`.
- `busy` out 1: high while in RUN.
- `done` out 1: one-cycle pulse when a sweep completes.
- `pass` out 1: last completed sweep had zero mismatches.
- `err_count` out N_INPUTS+1: mismatch count of the current or last sweep.
- `capture` out 2^N_INPUTS: sampled `y`; bit i holds the sample for input i.

## Operation
States are IDLE, RUN and DONE. Reset state is IDLE.

Reset (`rst_n` low) forces the following immediately, including mid-sweep:
- `x`=0, `busy`=0, `done`=0, `pass`=0, `err_count`=0, `capture`=0.
- `hold_cnt`=0, state IDLE.

IDLE:
- `x`=0.
- When `start`=1 at an edge: go to RUN, `x`=0, `hold_cnt`=0, `err_count`=0, `capture`=0, `pass`=0.

RUN:
- `hold_cnt` increments each edge.
- At the edge where `hold_cnt`==HOLD_CYCLES-1:
  - `capture[x]` <= `dut_y`.
  - `err_count` increments if `dut_y` != `EXPECTED[x]`.
  - If `x` != 2^N-1: `x` <= x+1 and `hold_cnt` <= 0.
  - Otherwise: go to DONE, `x` <= 0, `pass` <= (final err_count==0), where final err_count includes this last compare.
- `abort`=1 at any RUN edge:
  - Go to IDLE, `x` <= 0.
  - `pass` stays 0, no `done` pulse.
  - `capture` and `err_count` keep their partial values.
  - `abort` takes priority over a coincident final sample.

DONE:
- Lasts one cycle with `done`=1, then go to IDLE.
- `start` is ignored in DONE and during RUN.

Arithmetic:
- `err_count` cannot overflow; its maximum is 2^N, which fits in N+1 bits.
- `hold_cnt` is sized $clog2(HOLD_CYCLES+1).
- `x` never wraps: the increment is suppressed on the last combination.

## Timing
- Start is sampled at edge E.
- `x`=k is driven from edge E+k·H to edge E+(k+1)·H, exactly H cycles (H = HOLD_CYCLES).
- `dut_y` for combination k is sampled at edge E+(k+1)·H. The DUT has H-1 cycles plus one clock period to settle.
- `done` is high for the cycle following edge E+2^N·H; this is edge E+160 for the defaults.
- `busy` is high from E to E+2^N·H.
- Minimum start-to-start period is 2^N·H+2 cycles.
- `pass`, `err_count` and `capture` hold their values until the next accepted `start` or reset.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `sweeper_pkg` contains:
  - state typedef `sweep_state_t` {IDLE, RUN, DONE};
  - localparam function for the combination count (2^N).
- One sub-module, `sweep_hold_timer`:
  - H-cycle counter with `clear`/`enable` inputs and a `last` output (`hold_cnt`==H-1).
  - Reused for other exhaustive-stimulus sequencers.
- The FSM, `x` register and checker stay in the top.

## Test plan
- **Golden XOR3:** model `y`=x2^x1^x0, defaults, pulse `start` → `done` at E+160, `capture`=8'h96, `err_count`=0, `pass`=1, `x`=0 afterwards.
- **Stuck DUT:** tie `y`=0, EXPECTED=8'h96 → `err_count`=4, `capture`=8'h00, `pass`=0, `done` pulses once.
- **Abort:** assert `abort` at E+50 → IDLE at that edge, `busy`=0, no `done`, `pass`=0, `capture` bits 0–1 valid, `x`=0.
- **Async reset mid-sweep:** drop `rst_n` at E+75 between edges → all outputs 0 immediately. Then `start` → normal sweep.
- **Start held high:** → `start` ignored during RUN/DONE, second sweep begins at edge E+162, `err_count` cleared.
- **HOLD_CYCLES=1:** XOR3 model → `x` steps 0..7 on consecutive cycles, `done` at E+8, `pass`=1.
